// File: rtl/sc_lanectrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_lanectrl_if
// Description : Control/status bundle between the game sequencer and the
//               vehicle-lane controller.
//                 master : game sequencer (drives START/PAUSE/COLLISION/LEVEL)
//                 slave  : sc_lanectrl (drives LOAD_SHIFT/VEL/PATTERN/RUNNING)
// Signals     : SC_LANECTRL_START_In      1   (re)start request
//               SC_LANECTRL_PAUSE_In      1   freeze level
//               SC_LANECTRL_COLLISION_In  1   frog-hit event
//               SC_LANECTRL_LEVEL_In      2   game level 0..3
//               SC_LANECTRL_LOAD_SHIFT_Out 1  parallel-load strobe
//               SC_LANECTRL_VEL_Out       1   shift tick
//               SC_LANECTRL_PATTERN_Out   DATAWIDTH_BUS  lane bitmap
//               SC_LANECTRL_RUNNING_Out   1   high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_lanectrl_if #(
    parameter int DATAWIDTH_BUS = 8
);
    logic                     SC_LANECTRL_START_In;
    logic                     SC_LANECTRL_PAUSE_In;
    logic                     SC_LANECTRL_COLLISION_In;
    logic [1:0]               SC_LANECTRL_LEVEL_In;
    logic                     SC_LANECTRL_LOAD_SHIFT_Out;
    logic                     SC_LANECTRL_VEL_Out;
    logic [DATAWIDTH_BUS-1:0] SC_LANECTRL_PATTERN_Out;
    logic                     SC_LANECTRL_RUNNING_Out;

    modport master (
        output SC_LANECTRL_START_In,
        output SC_LANECTRL_PAUSE_In,
        output SC_LANECTRL_COLLISION_In,
        output SC_LANECTRL_LEVEL_In,
        input  SC_LANECTRL_LOAD_SHIFT_Out,
        input  SC_LANECTRL_VEL_Out,
        input  SC_LANECTRL_PATTERN_Out,
        input  SC_LANECTRL_RUNNING_Out
    );

    modport slave (
        input  SC_LANECTRL_START_In,
        input  SC_LANECTRL_PAUSE_In,
        input  SC_LANECTRL_COLLISION_In,
        input  SC_LANECTRL_LEVEL_In,
        output SC_LANECTRL_LOAD_SHIFT_Out,
        output SC_LANECTRL_VEL_Out,
        output SC_LANECTRL_PATTERN_Out,
        output SC_LANECTRL_RUNNING_Out
    );
endinterface
`default_nettype wire

// File: rtl/sc_lanectrl.sv
`default_nettype none
// ============================================================================
// Module      : sc_lanectrl
// Description : Upstream controller for the vehicle-lane shift register.
//               On START it issues a one-cycle parallel-load strobe with the
//               level's initial lane bitmap, then produces a periodic shift
//               tick whose period is BASE_PERIOD >> level (minimum 2).
//               PAUSE freezes the prescaler without losing phase; COLLISION
//               halts the lane until the next START.
// Ports       : SC_LANECTRL_CLOCK        in   system clock
//               SC_LANECTRL_RESET_InLow  in   asynchronous active-low reset
//               bus (sc_lanectrl_if.slave) control inputs / lane outputs
// Revision    : 1.0 - initial release
// ============================================================================
module sc_lanectrl #(
    parameter int                      DATAWIDTH_BUS = 8,
    parameter int                      PERIOD_WIDTH  = 24,
    parameter logic [PERIOD_WIDTH-1:0] BASE_PERIOD   = 24'd5000000
) (
    input  wire logic     SC_LANECTRL_CLOCK,
    input  wire logic     SC_LANECTRL_RESET_InLow,
    sc_lanectrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] c_MIN_PERIOD = PERIOD_WIDTH'(2);

    state_t                   r_state;
    state_t                   w_next;
    logic [PERIOD_WIDTH-1:0]  r_count;
    logic [PERIOD_WIDTH-1:0]  w_count_next;
    logic [1:0]               r_level;
    logic [DATAWIDTH_BUS-1:0] r_pattern;
    logic [DATAWIDTH_BUS-1:0] w_pattern_lut;
    logic [PERIOD_WIDTH-1:0]  w_shifted;
    logic [PERIOD_WIDTH-1:0]  w_period;
    logic [PERIOD_WIDTH-1:0]  w_last;
    logic                     w_latch;
    logic                     w_vel;
    logic                     w_load;

    // Tick period from the latched level; clamped so a tick can never be
    // back-to-back with itself at the fastest levels.
    assign w_shifted = BASE_PERIOD >> r_level;
    assign w_period  = (w_shifted < c_MIN_PERIOD) ? c_MIN_PERIOD : w_shifted;
    assign w_last    = w_period - PERIOD_WIDTH'(1);

    // Initial lane bitmap for the level being latched by START.
    always_comb begin
        w_pattern_lut = DATAWIDTH_BUS'(8'hC0);
        case (bus.SC_LANECTRL_LEVEL_In)
            2'd0:    w_pattern_lut = DATAWIDTH_BUS'(8'hC0);
            2'd1:    w_pattern_lut = DATAWIDTH_BUS'(8'hCC);
            2'd2:    w_pattern_lut = DATAWIDTH_BUS'(8'hDA);
            default: w_pattern_lut = DATAWIDTH_BUS'(8'hEE);
        endcase
    end

    // Next-state, counter and tick decode.
    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        w_vel        = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (bus.SC_LANECTRL_START_In) begin
                    w_next       = ST_LOAD;
                    w_latch      = 1'b1;
                    w_count_next = '0;
                end
            end
            ST_LOAD: begin
                w_count_next = '0;
                if (bus.SC_LANECTRL_START_In) begin
                    w_next  = ST_LOAD;
                    w_latch = 1'b1;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.SC_LANECTRL_COLLISION_In) begin
                    w_next       = ST_HALT;
                    w_count_next = '0;
                end else if (bus.SC_LANECTRL_START_In) begin
                    w_next       = ST_LOAD;
                    w_latch      = 1'b1;
                    w_count_next = '0;
                end else if (bus.SC_LANECTRL_PAUSE_In) begin
                    // Counter holds so the tick phase survives the pause.
                    w_next = ST_PAUSED;
                end else if (r_count == w_last) begin
                    w_vel        = 1'b1;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + PERIOD_WIDTH'(1);
                end
            end
            ST_PAUSED: begin
                if (bus.SC_LANECTRL_COLLISION_In) begin
                    w_next       = ST_HALT;
                    w_count_next = '0;
                end else if (bus.SC_LANECTRL_START_In) begin
                    w_next       = ST_LOAD;
                    w_latch      = 1'b1;
                    w_count_next = '0;
                end else if (!bus.SC_LANECTRL_PAUSE_In) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next       = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    assign w_load = (r_state == ST_LOAD);

    always_ff @(posedge SC_LANECTRL_CLOCK or negedge SC_LANECTRL_RESET_InLow) begin
        if (!SC_LANECTRL_RESET_InLow) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_level   <= 2'd0;
            r_pattern <= '0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            if (w_latch) begin
                r_level   <= bus.SC_LANECTRL_LEVEL_In;
                r_pattern <= w_pattern_lut;
            end
        end
    end

    // All outputs decode from registered state, so they drop with reset.
    assign bus.SC_LANECTRL_LOAD_SHIFT_Out = w_load;
    assign bus.SC_LANECTRL_VEL_Out        = w_vel;
    assign bus.SC_LANECTRL_PATTERN_Out    = r_pattern;
    assign bus.SC_LANECTRL_RUNNING_Out    = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_sc_lanectrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_lanectrl
// Description : Directed testbench for sc_lanectrl with BASE_PERIOD=16.
//               A cycle model predicts each cycle's outputs into a queue;
//               the prediction is popped and compared at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_lanectrl;

    localparam int          c_DW = 8;
    localparam int          c_PW = 24;
    localparam logic [23:0] c_BP = 24'd16;

    typedef struct {
        logic       load;
        logic       vel;
        logic       run;
        logic [7:0] pat;
    } exp_t;

    logic clk;
    logic rst_n;

    sc_lanectrl_if #(.DATAWIDTH_BUS(c_DW)) bus ();

    sc_lanectrl #(
        .DATAWIDTH_BUS (c_DW),
        .PERIOD_WIDTH  (c_PW),
        .BASE_PERIOD   (c_BP)
    ) dut (
        .SC_LANECTRL_CLOCK       (clk),
        .SC_LANECTRL_RESET_InLow (rst_n),
        .bus                     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    // Model state: 0 idle, 1 load, 2 run, 3 paused, 4 halt
    int         m_state;
    int         m_cnt;
    int         m_per;
    logic [7:0] m_pat;

    logic o_vel, o_load, o_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat_of(input logic [1:0] l);
        case (l)
            2'd0:    return 8'hC0;
            2'd1:    return 8'hCC;
            2'd2:    return 8'hDA;
            default: return 8'hEE;
        endcase
    endfunction

    function automatic int per_of(input logic [1:0] l);
        int p;
        p = 16 >> l;
        if (p < 2) p = 2;
        return p;
    endfunction

    task automatic model_latch(input logic [1:0] l);
        m_state = 1;
        m_cnt   = 0;
        m_per   = per_of(l);
        m_pat   = pat_of(l);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_per   = 16;
        m_pat   = 8'h00;
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic cyc(input logic s, input logic p, input logic c, input logic [1:0] l);
        exp_t e;
        bus.SC_LANECTRL_START_In     = s;
        bus.SC_LANECTRL_PAUSE_In     = p;
        bus.SC_LANECTRL_COLLISION_In = c;
        bus.SC_LANECTRL_LEVEL_In     = l;
        e.load = (m_state == 1);
        e.run  = (m_state == 2);
        e.vel  = (m_state == 2) && !c && !s && !p && (m_cnt == m_per - 1);
        e.pat  = m_pat;
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        o_vel  = bus.SC_LANECTRL_VEL_Out;
        o_load = bus.SC_LANECTRL_LOAD_SHIFT_Out;
        o_run  = bus.SC_LANECTRL_RUNNING_Out;
        check("load_strobe", {31'd0, o_load}, {31'd0, e.load});
        check("vel_tick",    {31'd0, o_vel},  {31'd0, e.vel});
        check("running",     {31'd0, o_run},  {31'd0, e.run});
        check("pattern",     {24'd0, bus.SC_LANECTRL_PATTERN_Out}, {24'd0, e.pat});
        check("load_vel_exclusive", {31'd0, o_load & o_vel}, 32'd0);
        @(posedge clk);
        case (m_state)
            0, 4: if (s) model_latch(l);
            1: begin
                if (s) model_latch(l);
                else begin m_state = 2; m_cnt = 0; end
            end
            2: begin
                if (c) begin m_state = 4; m_cnt = 0; end
                else if (s) model_latch(l);
                else if (p) m_state = 3;
                else if (m_cnt == m_per - 1) m_cnt = 0;
                else m_cnt++;
            end
            3: begin
                if (c) begin m_state = 4; m_cnt = 0; end
                else if (s) model_latch(l);
                else if (!p) m_state = 2;
            end
            default: m_state = 0;
        endcase
        #1;
    endtask

    initial begin
        int runidx, nload, nvel, active, relrun, first_rel, last_load, first_vel, idx;
        int vp[$];

        bus.SC_LANECTRL_START_In     = 1'b0;
        bus.SC_LANECTRL_PAUSE_In     = 1'b0;
        bus.SC_LANECTRL_COLLISION_In = 1'b0;
        bus.SC_LANECTRL_LEVEL_In     = 2'd0;
        rst_n = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check("rst_load",    {31'd0, bus.SC_LANECTRL_LOAD_SHIFT_Out}, 32'd0);
        check("rst_vel",     {31'd0, bus.SC_LANECTRL_VEL_Out},        32'd0);
        check("rst_running", {31'd0, bus.SC_LANECTRL_RUNNING_Out},    32'd0);
        check("rst_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out},    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'd0);

        // Level 0: one strobe, ticks at RUN cycles 16/32/48
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        nload = 0; runidx = 0; vp.delete();
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            if (o_load) nload++;
            if (o_run) runidx++;
            if (o_vel) vp.push_back(runidx);
        end
        check("l0_strobes", nload, 1);
        check("l0_nticks", vp.size(), 3);
        for (int i = 0; i < 3; i++) begin
            idx = (i < vp.size()) ? vp[i] : -1;
            check("l0_tick_pos", idx, 16 * (i + 1));
        end
        check("l0_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out}, 32'h000000C0);

        // Level 3: period 2, level change mid-run ignored
        cyc(1'b1, 1'b0, 1'b0, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 2'd3);
        check("l3_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out}, 32'h000000EE);
        nvel = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0, (i < 3) ? 2'd3 : 2'd0);
            if (o_vel) nvel++;
        end
        check("l3_nticks", nvel, 6);

        // Pause at counter=14 for 10 cycles
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        nvel = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            if (o_vel) nvel++;
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 2'd0);
            if (o_vel) nvel++;
        end
        check("pause_no_vel", nvel, 0);
        active = 14; relrun = 0; first_rel = -1;
        for (int g = 0; g < 300 && active < 100; g++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            if (o_run) begin active++; relrun++; end
            if (o_vel) begin
                nvel++;
                if (first_rel < 0) first_rel = relrun;
            end
        end
        check("pause_active_cycles", active, 100);
        check("pause_first_vel", first_rel, 2);
        check("pause_total_ticks", nvel, 6);

        // Collision at counter=15
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b1, 2'd0);
        check("coll_no_vel", {31'd0, o_vel}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check("coll_running", {31'd0, o_run}, 32'd0);
        check("coll_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out}, 32'h000000C0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'd1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check("l1_load", {31'd0, o_load}, 32'd1);
        check("l1_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out}, 32'h000000CC);
        runidx = 0; vp.delete();
        for (int i = 0; i < 17; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0);
            if (o_run) runidx++;
            if (o_vel) vp.push_back(runidx);
        end
        check("l1_nticks", vp.size(), 2);
        for (int i = 0; i < 2; i++) begin
            idx = (i < vp.size()) ? vp[i] : -1;
            check("l1_tick_pos", idx, 8 * (i + 1));
        end

        // START held three cycles
        nload = 0; last_load = -1; first_vel = -1;
        for (int i = 0; i < 24; i++) begin
            cyc((i < 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 2'd0);
            if (o_load) begin nload++; last_load = i; end
            if (o_vel && first_vel < 0) first_vel = i;
        end
        check("hold_strobes", nload, 3);
        check("hold_last_strobe", last_load, 3);
        check("hold_first_vel_gap", first_vel - last_load, 16);

        // Asynchronous reset mid-run at counter=9
        cyc(1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0);
        #2;
        check("pre_rst_running", {31'd0, bus.SC_LANECTRL_RUNNING_Out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_load",    {31'd0, bus.SC_LANECTRL_LOAD_SHIFT_Out}, 32'd0);
        check("arst_vel",     {31'd0, bus.SC_LANECTRL_VEL_Out},        32'd0);
        check("arst_running", {31'd0, bus.SC_LANECTRL_RUNNING_Out},    32'd0);
        check("arst_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out},    32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        nload = 0; nvel = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd1);
            if (o_load) nload++;
            if (o_vel) nvel++;
        end
        check("post_rst_no_load", nload, 0);
        check("post_rst_no_vel", nvel, 0);
        cyc(1'b1, 1'b0, 1'b0, 2'd2);
        cyc(1'b0, 1'b0, 1'b0, 2'd0);
        check("l2_pattern", {24'd0, bus.SC_LANECTRL_PATTERN_Out}, 32'h000000DA);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
